// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: bridges the memory-access stage to a word-aligned
// req/ack data bus. It generates byte enables and lane-replicated store data, and it
// extends load data. Illegal, misaligned and timed-out accesses are reported as errors.
module load_store_unit #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t           state;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [1:0]       offset_q;
  logic [CNT_W-1:0] cnt;

  logic             legal;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic [31:0]      rdata_shift;
  logic [15:0]      rdata_half;
  logic [31:0]      load_c;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  // Decode the incoming request; funct3[2] (unsigned) is only meaningful for byte/half loads.
  always_comb begin
    legal   = 1'b0;
    be_c    = 4'b0000;
    wdata_c = 32'h0;
    case (req_funct3[1:0])
      2'b00: begin
        legal   = 1'b1;
        be_c    = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        legal   = ~req_addr[0];
        be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        legal   = (req_addr[1:0] == 2'b00) && !req_funct3[2];
        be_c    = 4'b1111;
        wdata_c = req_wdata;
      end
      default: legal = 1'b0;
    endcase
    if (req_we && req_funct3[2]) legal = 1'b0;
  end

  always_comb begin
    rdata_shift = bus_rdata >> {offset_q, 3'b000};
    rdata_half  = offset_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3_q)
      3'b000:  load_c = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b001:  load_c = {{16{rdata_half[15]}}, rdata_half};
      3'b010:  load_c = bus_rdata;
      3'b100:  load_c = {24'h0, rdata_shift[7:0]};
      3'b101:  load_c = {16'h0, rdata_half};
      default: load_c = 32'h0;
    endcase
  end

  assign cnt_inc     = cnt + 1'b1;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYC));
  assign stall       = req_valid & ~done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      offset_q  <= 2'b00;
      cnt       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      load_data <= 32'h0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            offset_q <= req_addr[1:0];
            cnt      <= '0;
            if (legal) begin
              state     <= REQ;
              bus_req   <= 1'b1;
              bus_we    <= req_we;
              bus_addr  <= {req_addr[31:2], 2'b00};
              bus_be    <= be_c;
              bus_wdata <= wdata_c;
            end else begin
              state     <= RESP;
              done      <= 1'b1;
              err       <= 1'b1;
              load_data <= 32'h0;
            end
          end
        end
        REQ: begin
          cnt <= cnt_inc;
          // An ack on the timeout cycle still completes the access cleanly.
          if (bus_ack) begin
            state     <= RESP;
            bus_req   <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b0;
            load_data <= we_q ? 32'h0 : load_c;
          end else if (timeout_hit) begin
            state     <= RESP;
            bus_req   <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b1;
            load_data <= 32'h0;
          end
        end
        RESP: begin
          state   <= IDLE;
          done    <= 1'b0;
          bus_req <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, illegal accesses, timeout and reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations from the most recent access
  int          o_req_cycles;
  int          o_done_cycle;
  logic        o_unstable;
  logic        o_we;
  logic [31:0] o_addr;
  logic [3:0]  o_be;
  logic [31:0] o_wdata;
  logic        o_err;
  logic [31:0] o_load;
  logic        o_stall_t0;
  logic        o_stall_t1;
  logic        o_stall_done;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYC(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .err(err), .load_data(load_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one access; ack_at is the REQ cycle (1-based) carrying bus_ack, 0 = never.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_at, input logic [31:0] rdata);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    o_req_cycles = 0; o_done_cycle = -1; o_unstable = 1'b0;
    o_we = 1'b0; o_addr = 32'h0; o_be = 4'h0; o_wdata = 32'h0;
    o_err = 1'b0; o_load = 32'h0; o_stall_t1 = 1'b0; o_stall_done = 1'b1;
    #1 o_stall_t0 = stall;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) o_stall_t1 = stall;
      if (done) begin
        o_done_cycle = c; o_err = err; o_load = load_data; o_stall_done = stall;
        break;
      end
      if (bus_req) begin
        if (o_req_cycles == 0) begin
          o_we = bus_we; o_addr = bus_addr; o_be = bus_be; o_wdata = bus_wdata;
        end else if (o_we !== bus_we || o_addr !== bus_addr || o_be !== bus_be || o_wdata !== bus_wdata) begin
          o_unstable = 1'b1;
        end
        o_req_cycles++;
      end
      bus_ack   = (c == ack_at);
      bus_rdata = (c == ack_at) ? rdata : 32'hxxxx_xxxx;
    end
    req_valid = 1'b0; bus_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
    tick(); tick();
    n_checks++;
    if ({done, err, bus_req, bus_we, stall} !== 5'b0 || load_data !== 32'h0 ||
        bus_addr !== 32'h0 || bus_be !== 4'h0 || bus_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: done=%b err=%b req=%b we=%b stall=%b ld=%h addr=%h be=%b wd=%h, required all zero",
               done, err, bus_req, bus_we, stall, load_data, bus_addr, bus_be, bus_wdata);
    end
    rst = 1'b0;
    tick();
    $display("reset: checked reset values");
  endtask

  task automatic test_lw();
    run_access(1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);
    n_checks++;
    if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_we !== 1'b0 || o_req_cycles != 1) begin
      n_fail++;
      $display("FAIL lw_bus: addr=%h be=%b we=%b req_cycles=%0d, required 00000100 1111 0 1", o_addr, o_be, o_we, o_req_cycles);
    end
    n_checks++;
    if (o_done_cycle != 2 || o_err !== 1'b0 || o_load !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL lw_done: done_cycle=%0d err=%b load=%h, required 2 0 deadbeef", o_done_cycle, o_err, o_load);
    end
    n_checks++;
    if (o_stall_t0 !== 1'b1 || o_stall_t1 !== 1'b1 || o_stall_done !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_stall: t0=%b t1=%b done=%b, required 1 1 0", o_stall_t0, o_stall_t1, o_stall_done);
    end
    $display("LW 0x100: load=%h done_cycle=%0d", o_load, o_done_cycle);
  endtask

  task automatic test_loads_ext();
    logic [2:0]  f3 [4]  = '{3'b000, 3'b100, 3'b101, 3'b001};
    logic [31:0] ad [4]  = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [3:0]  be [4]  = '{4'b1000, 4'b1000, 4'b1100, 4'b1100};
    logic [31:0] ex [4]  = '{32'hFFFFFF80, 32'h00000080, 32'h00008012, 32'hFFFF8012};
    for (int i = 0; i < 4; i++) begin
      run_access(1'b0, f3[i], ad[i], 32'h0, 1, 32'h80123456);
      n_checks++;
      if (o_be !== be[i] || o_addr !== 32'h100 || o_load !== ex[i] || o_err !== 1'b0 || o_done_cycle != 2) begin
        n_fail++;
        $display("FAIL load_ext_%0d: be=%b addr=%h load=%h err=%b done_cycle=%0d, required be=%b addr=00000100 load=%h err=0 done_cycle=2",
                 i, o_be, o_addr, o_load, o_err, o_done_cycle, be[i], ex[i]);
      end
      $display("load f3=%b addr=%h: load=%h be=%b", f3[i], ad[i], o_load, o_be);
    end
  endtask

  task automatic test_stores();
    run_access(1'b1, 3'b001, 32'h206, 32'h0000ABCD, 4, 32'h11111111);
    n_checks++;
    if (o_be !== 4'b1100 || o_wdata !== 32'hABCDABCD || o_we !== 1'b1 || o_addr !== 32'h204 || o_unstable) begin
      n_fail++;
      $display("FAIL sh_bus: be=%b wd=%h we=%b addr=%h unstable=%b, required 1100 abcdabcd 1 00000204 0",
               o_be, o_wdata, o_we, o_addr, o_unstable);
    end
    n_checks++;
    if (o_req_cycles != 4 || o_done_cycle != 5 || o_load !== 32'h0 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sh_done: req_cycles=%0d done_cycle=%0d load=%h err=%b, required 4 5 00000000 0",
               o_req_cycles, o_done_cycle, o_load, o_err);
    end
    $display("SH 0x206: wd=%h be=%b req_cycles=%0d", o_wdata, o_be, o_req_cycles);
    run_access(1'b1, 3'b000, 32'h301, 32'h12345678, 2, 32'h0);
    n_checks++;
    if (o_be !== 4'b0010 || o_wdata !== 32'h78787878 || o_addr !== 32'h300 || o_done_cycle != 3 || o_load !== 32'h0) begin
      n_fail++;
      $display("FAIL sb: be=%b wd=%h addr=%h done_cycle=%0d load=%h, required 0010 78787878 00000300 3 00000000",
               o_be, o_wdata, o_addr, o_done_cycle, o_load);
    end
    $display("SB 0x301: wd=%h be=%b", o_wdata, o_be);
  endtask

  task automatic test_illegal();
    logic        we [3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0]  f3 [3] = '{3'b010, 3'b011, 3'b100};
    logic [31:0] ad [3] = '{32'h101, 32'h100, 32'h100};
    for (int i = 0; i < 3; i++) begin
      run_access(we[i], f3[i], ad[i], 32'hFFFFFFFF, 1, 32'hFFFFFFFF);
      n_checks++;
      if (o_req_cycles != 0 || o_done_cycle != 1 || o_err !== 1'b1 || o_load !== 32'h0) begin
        n_fail++;
        $display("FAIL illegal_%0d: req_cycles=%0d done_cycle=%0d err=%b load=%h, required 0 1 1 00000000",
                 i, o_req_cycles, o_done_cycle, o_err, o_load);
      end
      $display("illegal we=%b f3=%b addr=%h: err=%b", we[i], f3[i], ad[i], o_err);
    end
  endtask

  task automatic test_timeout();
    run_access(1'b0, 3'b010, 32'h400, 32'h0, 0, 32'h0);
    n_checks++;
    if (o_req_cycles != 4 || o_done_cycle != 5 || o_err !== 1'b1 || o_load !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout: req_cycles=%0d done_cycle=%0d err=%b load=%h, required 4 5 1 00000000",
               o_req_cycles, o_done_cycle, o_err, o_load);
    end
    $display("timeout: req_cycles=%0d err=%b", o_req_cycles, o_err);
    run_access(1'b0, 3'b010, 32'h400, 32'h0, 4, 32'h13572468);
    n_checks++;
    if (o_req_cycles != 4 || o_done_cycle != 5 || o_err !== 1'b0 || o_load !== 32'h13572468) begin
      n_fail++;
      $display("FAIL ack_at_timeout: req_cycles=%0d done_cycle=%0d err=%b load=%h, required 4 5 0 13572468",
               o_req_cycles, o_done_cycle, o_err, o_load);
    end
    $display("ack on timeout cycle: err=%b load=%h", o_err, o_load);
  endtask

  task automatic test_reset_in_req();
    logic seen_done = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500;
    tick(); tick();
    n_checks++;
    if (bus_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_req: bus_req=%b, required 1", bus_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    n_checks++;
    if (bus_req !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_req: bus_req=%b done=%b, required 0 0", bus_req, done);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      bus_ack = 1'b0;
      if (done || bus_req) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL late_ack: done or bus_req seen=%b, required 0", seen_done);
    end
    $display("reset during REQ: late ack ignored=%b", !seen_done);
    run_access(1'b0, 3'b010, 32'h600, 32'h0, 2, 32'h0BADC0DE);
    n_checks++;
    if (o_done_cycle != 3 || o_err !== 1'b0 || o_load !== 32'h0BADC0DE || o_addr !== 32'h600) begin
      n_fail++;
      $display("FAIL post_rst_lw: done_cycle=%0d err=%b load=%h addr=%h, required 3 0 0badc0de 00000600",
               o_done_cycle, o_err, o_load, o_addr);
    end
    $display("LW after reset: load=%h", o_load);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_loads_ext();
    test_stores();
    test_illegal();
    test_timeout();
    test_reset_in_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle load/store unit between the memory-access pipeline stage and the data-memory bus; replaces the single-cycle dmem port.
- Accepts one access per request, drives a word-aligned req/ack bus with byte enables, and returns sign/zero-extended load data to the writeback stage.
- Holds the pipeline via `stall` until the access completes, and flags misaligned, reserved or timed-out accesses.

Parameters:
- TIMEOUT_CYC, 16: number of REQ cycles without `bus_ack` before the access aborts with error; 0 disables the timeout.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  access-stage instruction is a load or store.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 funct3 of the load/store.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- stall  out  1  hold upstream pipeline registers.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with `done`; access faulted.
- load_data  out  32  extended load result, valid with `done`.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_addr  out  32  word address, bits [1:0] = 00.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-aligned write data.
- bus_rdata  in  32  read data, valid with `bus_ack`.
- bus_ack  in  1  bus completion.

Behaviour:
- Reset values:
  - State is IDLE.
  - `done`, `err`, `bus_req`, `bus_we` = 0.
  - `load_data`, `bus_addr`, `bus_be`, `bus_wdata` = 0.
  - Timeout counter = 0.
- State machine has three states: IDLE, REQ, RESP.
- IDLE:
  - On `req_valid` = 1, latch we, funct3, addr and wdata.
  - If the access is legal, go to REQ.
  - If it is illegal, go to RESP with the error flag set; no bus activity occurs.
- Legal funct3 values:
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Misalignment is also illegal:
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] != 00.
- REQ:
  - `bus_req` = 1, with `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` registered and stable for the whole state.
  - Counter increments each cycle.
  - `bus_ack` = 1 goes to RESP: latch the load result and set err = 0.
  - If counter reaches TIMEOUT_CYC (nonzero) with no ack, go to RESP with err = 1 and `bus_req` drops.
  - An ack on the same cycle as the timeout wins.
- RESP:
  - `done` = 1 for exactly one cycle, `bus_req` = 0, then return to IDLE.
  - `load_data` = 0 on error, and 0 for stores.
- Byte enables:
  - Byte access: 0001 shifted left by addr[1:0].
  - Half access: 0011 for addr[1] = 0, 1100 for addr[1] = 1.
  - Word access: 1111.
- Store data is replicated across lanes:
  - SB: byte replicated ×4.
  - SH: half replicated ×2.
  - SW: passed through.
- Load extraction:
  - Select the byte or half lane from `bus_rdata` using addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- `stall` = `req_valid` & ~`done` (combinational). It is low in the RESP cycle so the pipeline advances, and a new request is taken on the following IDLE cycle.
- Latency from the IDLE accept cycle (t0):
  - `bus_req` is high from t1.
  - With ack at cycle tk, `done` is at tk+1; minimum is done at t2 for a zero-wait bus.
  - An illegal access gives done at t1.
- `req_valid` dropping during REQ does not abort the access; it completes normally.
- `bus_ack` in IDLE or RESP is ignored.
- Reset asserted in any state returns everything to reset values on the next edge. An ack arriving after reset is ignored.

Test Plan:
- LW addr 0x100, zero-wait ack, rdata 0xDEADBEEF -> `bus_addr` 0x100, be 1111, `done` at t2, `load_data` 0xDEADBEEF, err 0, `stall` high t0–t1.
- LB addr 0x103, rdata 0x80123456 -> be 1000, `load_data` 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr 0x102 -> 0x00008012.
- SH addr 0x206, wdata 0x0000ABCD, ack after 3 wait cycles -> be 1100, `bus_wdata` 0xABCDABCD, `bus_we` 1, `bus_req` held 4 cycles, `done` one cycle after ack, `load_data` 0.
- LW addr 0x101 and funct3 011 -> no `bus_req`, `done` at t1 with err 1, `load_data` 0.
- TIMEOUT_CYC = 4, ack never arrives -> `bus_req` high exactly 4 cycles, then `done` with err 1. Repeat with ack on the 4th REQ cycle -> err 0.
- `rst` pulsed during REQ, then a late ack -> `bus_req` 0 after the reset edge, no `done`. A subsequent LW completes normally.
